// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong buffer turning bit-reversed FFT output into natural order
// Optional natural-bin index port ctr_o is enabled by defining FFT_BITREV_REORDER_CTR_EN.
`timescale 1ns/1ps
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 25,
    parameter int N_LOG2     = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         valid_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
`ifdef FFT_BITREV_REORDER_CTR_EN
    output logic signed [DATA_WIDTH-1:0] z_im_o,
    output logic        [N_LOG2-1:0]     ctr_o
`else
    output logic signed [DATA_WIDTH-1:0] z_im_o
`endif
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST = '1;

    typedef enum logic {IDLE, READ} state_t;

    logic [2*DATA_WIDTH-1:0] mem [2*N];

    logic [N_LOG2-1:0] wr_ctr;
    logic              wr_bank;
    logic              pending;
    logic              pend_bank;
    logic              set_pend;

    state_t            state, state_n;
    logic [N_LOG2-1:0] rd_ctr, rd_ctr_n;
    logic              rd_bank, rd_bank_n;
    logic              take;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = a[N_LOG2-1-i];
        end
        return r;
    endfunction

    assign set_pend = valid_i && (wr_ctr == LAST);

    always_ff @(posedge clk_i) begin
        if (valid_i && rst_n) begin
            mem[{wr_bank, bitrev(wr_ctr)}] <= {x_re_i, x_im_i};
        end
    end

    // A frame completing in the same cycle the reader hands over is consumed immediately.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ctr    <= '0;
            wr_bank   <= 1'b0;
            pending   <= 1'b0;
            pend_bank <= 1'b0;
        end else begin
            if (valid_i) begin
                wr_ctr <= wr_ctr + 1'b1;
            end
            if (set_pend) begin
                wr_bank   <= ~wr_bank;
                pend_bank <= wr_bank;
                pending   <= !(take && !pending);
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_ctr  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_n;
            rd_ctr  <= rd_ctr_n;
            rd_bank <= rd_bank_n;
        end
    end

    always_comb begin
        state_n   = state;
        rd_ctr_n  = rd_ctr;
        rd_bank_n = rd_bank;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_n   = READ;
                    take      = 1'b1;
                    rd_ctr_n  = '0;
                    rd_bank_n = pend_bank;
                end
            end
            READ: begin
                rd_ctr_n = rd_ctr + 1'b1;
                if (rd_ctr == LAST) begin
                    if (pending || set_pend) begin
                        take      = 1'b1;
                        rd_bank_n = ~rd_bank;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered RAM read; outputs hold their last sample while valid_o is low.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            z_re_o  <= '0;
            z_im_o  <= '0;
`ifdef FFT_BITREV_REORDER_CTR_EN
            ctr_o   <= '0;
`endif
        end else begin
            valid_o <= (state == READ);
            if (state == READ) begin
                {z_re_o, z_im_o} <= mem[{rd_bank, rd_ctr}];
`ifdef FFT_BITREV_REORDER_CTR_EN
                ctr_o <= rd_ctr;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder (N = 8)
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

    localparam int DW = 25;
    localparam int NL = 3;
    localparam int N  = 8;

    logic                 clk_i   = 1'b0;
    logic                 rst_n   = 1'b0;
    logic                 valid_i = 1'b0;
    logic signed [DW-1:0] x_re_i  = '0;
    logic signed [DW-1:0] x_im_i  = '0;
    logic                 valid_o;
    logic signed [DW-1:0] z_re_o;
    logic signed [DW-1:0] z_im_o;
`ifdef FFT_BITREV_REORDER_CTR_EN
    logic [NL-1:0]        ctr_o;
`endif

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_LOG2(NL)) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .x_re_i  (x_re_i),
        .x_im_i  (x_im_i),
        .valid_o (valid_o),
        .z_re_o  (z_re_o),
`ifdef FFT_BITREV_REORDER_CTR_EN
        .z_im_o  (z_im_o),
        .ctr_o   (ctr_o)
`else
        .z_im_o  (z_im_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: each completed frame is reordered as out[n] = in[bitrev(n)].
    typedef struct { int c; logic signed [DW-1:0] re; logic signed [DW-1:0] im; int bin; } exp_t;
    typedef struct { int c; logic signed [DW-1:0] re; logic signed [DW-1:0] im; } obs_t;
    exp_t expq[$];
    obs_t seen[$];
    logic signed [DW-1:0] fin_re [N];
    logic signed [DW-1:0] fin_im [N];
    int fcnt       = 0;
    int prev_start = -1000;
    logic signed [DW-1:0] last_re = '0;
    logic signed [DW-1:0] last_im = '0;

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < NL; i++) if ((k >> i) & 1) r |= 1 << (NL - 1 - i);
        return r;
    endfunction

    always @(negedge rst_n) begin
        expq.delete();
        fcnt       = 0;
        prev_start = -1000;
        last_re    = '0;
        last_im    = '0;
    end

    always @(negedge clk_i) begin
        exp_t e;
        obs_t o;
        if (!rst_n) begin
            check("rst_valid_o", longint'(valid_o), 0);
            check("rst_z_re", z_re_o, 0);
            check("rst_z_im", z_im_o, 0);
`ifdef FFT_BITREV_REORDER_CTR_EN
            check("rst_ctr", longint'(ctr_o), 0);
`endif
        end else if (valid_o) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid_o=1 z_re=%0d expected no output (cycle %0d)", z_re_o, cyc);
            end else begin
                e = expq.pop_front();
                check("out_cycle", cyc, e.c);
                check("out_re", z_re_o, e.re);
                check("out_im", z_im_o, e.im);
`ifdef FFT_BITREV_REORDER_CTR_EN
                check("out_ctr", longint'(ctr_o), e.bin);
`endif
                last_re = e.re;
                last_im = e.im;
            end
            o.c  = cyc;
            o.re = z_re_o;
            o.im = z_im_o;
            seen.push_back(o);
        end else begin
            check("hold_re", z_re_o, last_re);
            check("hold_im", z_im_o, last_im);
            if (expq.size() > 0 && expq[0].c <= cyc) begin
                e = expq.pop_front();
                check("missing_output_cycle", cyc + 1, e.c);
            end
        end
        // Inputs seen here are sampled at the coming edge, cyc+1.
        if (rst_n && valid_i) begin
            fin_re[fcnt] = x_re_i;
            fin_im[fcnt] = x_im_i;
            fcnt++;
            if (fcnt == N) begin
                int l;
                int start;
                l     = cyc + 1;
                start = (l + 1 <= prev_start + N) ? prev_start + N : l + 2;
                for (int n = 0; n < N; n++) begin
                    e.c   = start + n;
                    e.re  = fin_re[rev(n)];
                    e.im  = fin_im[rev(n)];
                    e.bin = n;
                    expq.push_back(e);
                end
                prev_start = start;
                fcnt       = 0;
            end
        end
    end

    task automatic drive(input bit v, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
        valid_i = v;
        x_re_i  = re;
        x_im_i  = im;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic wait_seen(input string nm, input int n, input int budget);
        int k = 0;
        while (seen.size() < n && k < budget) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check(nm, seen.size(), n);
    endtask

    typedef struct {
        logic [N-1:0][DW-1:0] re;
        logic [N-1:0][DW-1:0] im;
        logic [N-1:0][DW-1:0] exp_re;
        logic [N-1:0][DW-1:0] exp_im;
        bit                   gap;
    } vec_t;
    vec_t tbl[3];

    task automatic send_two(input bit gap_second);
        int ord[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int k = 0; k < N; k++) drive(1'b1, DW'(ord[k]), DW'(-ord[k]));
        for (int k = 0; k < N; k++) begin
            if (gap_second && k == 3) drive(1'b0, '0, '0);
            drive(1'b1, DW'(ord[k] + 8), DW'(-ord[k] - 8));
        end
        valid_i = 1'b0;
    endtask

    initial begin
        int ord[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int pv;
        int mv;
        pv = (1 << 24) - 1;
        mv = -(1 << 24);
        for (int k = 0; k < N; k++) begin
            tbl[0].re[k] = DW'(ord[k]);
            tbl[0].im[k] = DW'(100 + ord[k]);
            tbl[0].exp_re[k] = DW'(k);
            tbl[0].exp_im[k] = DW'(100 + k);
            tbl[1].re[k] = DW'(ord[k]);
            tbl[1].im[k] = DW'(-ord[k]);
            tbl[1].exp_re[k] = DW'(k);
            tbl[1].exp_im[k] = DW'(-k);
            tbl[2].re[k] = DW'((k < 4) ? pv : mv);
            tbl[2].im[k] = DW'((k < 4) ? -pv : mv);
            tbl[2].exp_re[k] = DW'((k % 2 == 0) ? pv : mv);
            tbl[2].exp_im[k] = DW'((k % 2 == 0) ? -pv : mv);
        end
        tbl[0].gap = 1'b0;
        tbl[1].gap = 1'b1;
        tbl[2].gap = 1'b0;

        @(posedge clk_i);
        #1;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        for (int t = 0; t < 3; t++) begin
            seen.delete();
            for (int k = 0; k < N; k++) begin
                drive(1'b1, tbl[t].re[k], tbl[t].im[k]);
                if (tbl[t].gap) drive(1'b0, DW'($urandom), DW'($urandom));
            end
            valid_i = 1'b0;
            wait_seen($sformatf("tbl%0d_count", t), N, 40);
            for (int n = 0; n < N && n < seen.size(); n++) begin
                check($sformatf("tbl%0d_re[%0d]", t, n), seen[n].re, signed'(tbl[t].exp_re[n]));
                check($sformatf("tbl%0d_im[%0d]", t, n), seen[n].im, signed'(tbl[t].exp_im[n]));
            end
            idle(4);
        end

        for (int g = 0; g < 2; g++) begin
            seen.delete();
            send_two(g[0]);
            wait_seen($sformatf("b2b%0d_count", g), 2 * N, 60);
            for (int n = 0; n < 2 * N && n < seen.size(); n++) begin
                check($sformatf("b2b%0d_re[%0d]", g, n), seen[n].re, n);
                check($sformatf("b2b%0d_gapless[%0d]", g, n), seen[n].c, seen[0].c + n);
            end
            idle(4);
        end

        seen.delete();
        for (int k = 0; k < 5; k++) drive(1'b1, DW'(1000 + k), DW'(k));
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) drive(1'b1, DW'(ord[k]), DW'(ord[k]));
        valid_i = 1'b0;
        wait_seen("midframe_rst_count", N, 40);
        for (int n = 0; n < N && n < seen.size(); n++) check($sformatf("midframe_rst_re[%0d]", n), seen[n].re, n);
        idle(4);

        seen.delete();
        for (int k = 0; k < N; k++) drive(1'b1, DW'(ord[k] + 40), DW'(ord[k]));
        valid_i = 1'b0;
        for (int k = 0; k < 40 && seen.size() < 4; k++) begin
            @(negedge clk_i);
            #1;
        end
        check("readout_rst_reach_bin3", seen.size(), 4);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_o", longint'(valid_o), 0);
        check("async_rst_z_re", z_re_o, 0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        idle(20);
        check("readout_rst_no_more", seen.size(), 4);

        for (int f = 0; f < 20; f++) begin
            bit dense;
            dense = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < N; k++) begin
                while (!dense && $urandom_range(0, 3) == 0) drive(1'b0, DW'($urandom), DW'($urandom));
                drive(1'b1, DW'($urandom), DW'($urandom));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
        end
        valid_i = 1'b0;
        for (int k = 0; k < 100 && expq.size() > 0; k++) idle(1);
        check("drain_pending_outputs", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
